// File: rtl/fpu_issue.sv
// fpu_issue: issue/writeback sequencer placed directly in front of the FPU wrapper.
// It takes one decoded FP instruction, holds the FPU operands stable, and raises
// fpu_distinct so the FPU sees a rising edge. The pipeline is stalled until the
// FPU reports valid, and then the block emits a one-cycle writeback.
//
// Ports:
//   CLK, reset            clock; synchronous active-low reset
//   issue_valid/ready     instruction handshake from register-read
//   ALUOp_in, rd_in,
//   op1_in, op2_in        decoded instruction fields
//   fpu_*  (out)          FPU inputs: AorF, ALUOp, op1, op2, distinct_
//   fpu_valid, fpu_result,
//   fpu_AorF_  (in)       FPU result, and where it goes (1 = FP reg, 0 = int reg)
//   stall                 pipeline hold while an operation is in flight
//   wb_valid/fp/rd/data   one-cycle writeback; the fields hold between strobes
//   illegal_op            one-cycle pulse for an unsupported ALUOp
//   err_timeout           sticky, set when the FPU never answers
//
// state  | meaning
// S_IDLE | ready for an instruction, FPU idle
// S_WAIT | fpu_distinct high, waiting for fpu_valid or a timeout
// S_GAP  | fpu_distinct low, waiting for the FPU to drop valid
module fpu_issue #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       ALUOp_in,
  input  logic [TAG_W-1:0] rd_in,
  input  logic [31:0]      op1_in,
  input  logic [31:0]      op2_in,
  output logic             fpu_AorF,
  output logic [3:0]       fpu_ALUOp,
  output logic [31:0]      fpu_op1,
  output logic [31:0]      fpu_op2,
  output logic             fpu_distinct,
  input  logic             fpu_valid,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_AorF_,
  output logic             stall,
  output logic             wb_valid,
  output logic             wb_fp,
  output logic [TAG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             illegal_op,
  output logic             err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Terminal count: the TIMEOUT-th WAIT cycle ends without a result.
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       aluop_q, aluop_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_fp_q, wb_fp_d;
  logic [TAG_W-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             illegal_q, illegal_d;
  logic             err_q, err_d;
  logic             legal;

  always_comb begin
    legal = 1'b0;
    case (ALUOp_in)
      4'b0011, 4'b0100, 4'b1110, 4'b1101,
      4'b1100, 4'b1011, 4'b1010: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    aluop_d    = aluop_q;
    rd_d       = rd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    wb_valid_d = 1'b0;
    wb_fp_d    = wb_fp_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          // An illegal op is dropped before it reaches the FPU inputs, so the
          // FPU sees no activity at all.
          if (legal) begin
            aluop_d = ALUOp_in;
            rd_d    = rd_in;
            op1_d   = op1_in;
            op2_d   = op2_in;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A result on the terminal cycle still wins over the timeout.
        if (fpu_valid) begin
          wb_valid_d = 1'b1;
          wb_fp_d    = fpu_AorF_;
          wb_rd_d    = rd_q;
          wb_data_d  = fpu_result;
          state_d    = S_GAP;
        end else if (cnt_q == TC) begin
          err_d   = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        // The FPU holds valid for two cycles; leaving only once it drops
        // keeps the stale valid from being taken as the next op's result.
        if (!fpu_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      aluop_q    <= '0;
      rd_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_fp_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aluop_q    <= aluop_d;
      rd_q       <= rd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      wb_valid_q <= wb_valid_d;
      wb_fp_q    <= wb_fp_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
    end
  end

  assign issue_ready  = (state_q == S_IDLE);
  assign stall        = (state_q != S_IDLE);
  assign fpu_distinct = (state_q == S_WAIT);
  assign fpu_AorF     = (state_q == S_WAIT);
  assign fpu_ALUOp    = aluop_q;
  assign fpu_op1      = op1_q;
  assign fpu_op2      = op2_q;
  assign wb_valid     = wb_valid_q;
  assign wb_fp        = wb_fp_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign illegal_op   = illegal_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Testbench for fpu_issue. A behavioural FPU stub answers each rising edge of
// fpu_distinct. Expected writebacks go into a queue when an instruction is
// accepted, and they are popped when wb_valid is seen.
module tb_fpu_issue;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 16;

  logic             CLK = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       ALUOp_in;
  logic [TAG_W-1:0] rd_in;
  logic [31:0]      op1_in, op2_in;
  logic             fpu_AorF;
  logic [3:0]       fpu_ALUOp;
  logic [31:0]      fpu_op1, fpu_op2;
  logic             fpu_distinct;
  logic             fpu_valid;
  logic [31:0]      fpu_result;
  logic             fpu_AorF_;
  logic             stall;
  logic             wb_valid, wb_fp;
  logic [TAG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             illegal_op, err_timeout;

  always #5 CLK = ~CLK;

  fpu_issue #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ALUOp_in(ALUOp_in), .rd_in(rd_in), .op1_in(op1_in), .op2_in(op2_in),
    .fpu_AorF(fpu_AorF), .fpu_ALUOp(fpu_ALUOp), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
    .fpu_distinct(fpu_distinct), .fpu_valid(fpu_valid), .fpu_result(fpu_result),
    .fpu_AorF_(fpu_AorF_), .stall(stall),
    .wb_valid(wb_valid), .wb_fp(wb_fp), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal_op(illegal_op), .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic             fp;
    logic [TAG_W-1:0] rd;
    logic [31:0]      data;
  } wb_t;
  wb_t exp_q[$];

  // The stub FPU works out results for the operand pairs the bench uses.
  // It compares positive IEEE floats as integers.
  function automatic logic [31:0] fpu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    case (op)
      4'b0011: if (a == 32'h3F80_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
      4'b0100: if (a == 32'h4040_0000 && b == 32'h3F80_0000) r = 32'h4000_0000;
      4'b1110: begin
        if (a == 32'h4000_0000 && b == 32'h4040_0000) r = 32'h40C0_0000;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) r = 32'h4000_0000;
      end
      4'b1101: if (a == 32'h40C0_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
      4'b1100: r = {31'd0, a == b};
      4'b1011: r = {31'd0, a <= b};
      4'b1010: r = {31'd0, a < b};
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  bit fpu_en = 1'b1;
  bit stub_prev = 1'b0;

  // FPU stub: three cycles after a rising edge on fpu_distinct it presents the
  // result with valid, and it holds valid for two cycles.
  initial begin
    fpu_valid  = 1'b0;
    fpu_result = '0;
    fpu_AorF_  = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (fpu_en && fpu_distinct && !stub_prev) begin
        repeat (3) @(posedge CLK);
        #1;
        fpu_result = fpu_model(fpu_ALUOp, fpu_op1, fpu_op2);
        fpu_AorF_  = fpu_ALUOp inside {4'b0011, 4'b0100, 4'b1110, 4'b1101};
        fpu_valid  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        fpu_valid = 1'b0;
      end
      stub_prev = fpu_distinct;
    end
  end

  int n_wb = 0, n_rise = 0, n_wait = 0, n_ill = 0;
  int low_run = 0, last_low = 0;
  bit mon_prev_dist = 1'b0, mon_prev_wb = 1'b0;

  initial begin
    wb_t e;
    forever begin
      @(negedge CLK);
      if (wb_valid) begin
        n_wb++;
        check("wb_stall", 32'(stall), 32'd1);
        if (mon_prev_wb) check("wb_pulse_len", 32'd2, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wb_fp", 32'(wb_fp), 32'(e.fp));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
        end else begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end
      end
      if (fpu_distinct) begin
        n_wait++;
        if (!mon_prev_dist) begin
          n_rise++;
          last_low = low_run;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      if (illegal_op) n_ill++;
      mon_prev_dist = fpu_distinct;
      mon_prev_wb   = wb_valid;
    end
  end

  int acc_wb = 0;

  task automatic step();
    @(negedge CLK); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [TAG_W-1:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic fp, input logic [31:0] data);
    int n;
    wb_t e;
    n = 0;
    step();
    issue_valid = 1'b1;
    ALUOp_in    = op;
    rd_in       = rd;
    op1_in      = a;
    op2_in      = b;
    while (!issue_ready && n < 300) begin
      step();
      n++;
    end
    if (!issue_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    acc_wb = n_wb;
    if (push) begin
      e.fp = fp; e.rd = rd; e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!issue_ready && n < 300) begin
      step();
      n++;
    end
    if (!issue_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_wb(input int target);
    int n;
    n = 0;
    while (n_wb < target && n < 300) begin
      step();
      n++;
    end
    check("wb_count", n_wb, target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, w0, wt0, i0, n;
    reset = 1'b0; issue_valid = 1'b0; ALUOp_in = '0; rd_in = '0; op1_in = '0; op2_in = '0;
    repeat (2) step();
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_distinct", 32'(fpu_distinct), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_fpu_op1", fpu_op1, 32'd0);
    reset = 1'b1;

    // fadd
    r0 = n_rise; w0 = n_wb;
    issue(4'b0011, 5'd7, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4040_0000);
    step();
    issue_valid = 1'b0;
    check("fadd_stall", 32'(stall), 32'd1);
    check("fadd_ready", 32'(issue_ready), 32'd0);
    check("fadd_aorf", 32'(fpu_AorF), 32'd1);
    wait_wb(w0 + 1);
    wait_ready();
    check("fadd_rises", n_rise - r0, 32'd1);
    check("fadd_wb_pulses", n_wb - w0, 32'd1);
    check("wb_hold", wb_data, 32'h4040_0000);

    // compares
    w0 = n_wb;
    issue(4'b1010, 5'd3, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0, 32'h0000_0001);
    step(); issue_valid = 1'b0;
    wait_wb(w0 + 1); wait_ready();
    issue(4'b1100, 5'd4, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0, 32'h0000_0000);
    step(); issue_valid = 1'b0;
    wait_wb(w0 + 2); wait_ready();

    // back-to-back fdiv then fmul with issue_valid held
    w0 = n_wb;
    issue(4'b1101, 5'd9, 32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4040_0000);
    issue(4'b1110, 5'd12, 32'h4000_0000, 32'h4040_0000, 1'b1, 1'b1, 32'h40C0_0000);
    check("b2b_order", acc_wb - w0, 32'd1);
    step(); issue_valid = 1'b0;
    check("b2b_gap_low", last_low, 32'd3);
    wait_wb(w0 + 2); wait_ready();

    // illegal ALUOp
    r0 = n_rise; w0 = n_wb; i0 = n_ill;
    issue(4'b0000, 5'd1, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0);
    step(); issue_valid = 1'b0;
    check("ill_pulse", 32'(illegal_op), 32'd1);
    check("ill_ready", 32'(issue_ready), 32'd1);
    step();
    check("ill_pulse_end", 32'(illegal_op), 32'd0);
    repeat (6) step();
    check("ill_pulse_count", n_ill - i0, 32'd1);
    check("ill_no_rise", n_rise - r0, 32'd0);
    check("ill_no_wb", n_wb - w0, 32'd0);

    // timeout with a silent FPU
    fpu_en = 1'b0;
    w0 = n_wb; wt0 = n_wait;
    issue(4'b0011, 5'd6, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h0);
    step(); issue_valid = 1'b0;
    n = 0;
    while (!err_timeout && n < 100) begin
      step();
      n++;
    end
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_wait_cycles", n_wait - wt0, TIMEOUT);
    wait_ready();
    check("to_no_wb", n_wb - w0, 32'd0);
    fpu_en = 1'b1;
    issue(4'b0100, 5'd5, 32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 32'h4000_0000);
    step(); issue_valid = 1'b0;
    wait_wb(w0 + 1); wait_ready();
    check("to_err_sticky", 32'(err_timeout), 32'd1);

    // reset in the middle of WAIT
    w0 = n_wb;
    issue(4'b1110, 5'd2, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h0);
    step(); issue_valid = 1'b0;
    check("mid_in_wait", 32'(fpu_distinct), 32'd1);
    reset = 1'b0;
    step();
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_distinct", 32'(fpu_distinct), 32'd0);
    check("mid_err", 32'(err_timeout), 32'd0);
    check("mid_ready", 32'(issue_ready), 32'd1);
    check("mid_wbdata", wb_data, 32'd0);
    reset = 1'b1;
    repeat (10) step();
    check("mid_no_wb", n_wb - w0, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Issue/writeback sequencer that sits directly upstream of the FPU wrapper and consumes its result.
- Accepts one decoded FP instruction (ALUOp, rd, two operands) from register-read and holds the FPU inputs stable for the whole operation.
- Generates the level edge the FPU edge-detects, stalls the pipeline until the FPU reports valid, then emits a one-cycle writeback tagged with the destination and register file (FP or integer).

Parameters:
- TAG_W, 5, destination register index width.
- TIMEOUT, 255, maximum cycles in WAIT before abort; counter width is clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-low (0 = reset)
- issue_valid  in  1  decode presents an FP instruction
- issue_ready  out  1  block can accept (state IDLE)
- ALUOp_in  in  4  FP operation code
- rd_in  in  TAG_W  destination register
- op1_in  in  32  first operand
- op2_in  in  32  second operand
- fpu_AorF  out  1  drives FPU AorF
- fpu_ALUOp  out  4  drives FPU ALUOp
- fpu_op1  out  32  drives FPU op1
- fpu_op2  out  32  drives FPU op2
- fpu_distinct  out  1  drives FPU distinct_ (FPU edge-detects it)
- fpu_valid  in  1  FPU result valid
- fpu_result  in  32  FPU result
- fpu_AorF_  in  1  FPU destination select: 1 = FP reg, 0 = integer reg
- stall  out  1  pipeline hold
- wb_valid  out  1  one-cycle writeback strobe
- wb_fp  out  1  writeback targets FP register file
- wb_rd  out  TAG_W  writeback destination
- wb_data  out  32  writeback data
- illegal_op  out  1  one-cycle pulse on unsupported ALUOp
- err_timeout  out  1  sticky abort flag

Behaviour:
- Legal ALUOps: 0011 fadd, 0100 fsub, 1110 fmul, 1101 fdiv, 1100 fceq, 1011 fcle, 1010 fclt.
- Reset (reset==0 at posedge): state IDLE; all outputs 0 except issue_ready=1; counter 0; err_timeout cleared. Reset mid-operation aborts with no writeback.
- States: IDLE, WAIT, GAP.
- IDLE: issue_ready=1, stall=0, fpu_distinct=0.
  - Accept on issue_valid&&issue_ready at posedge T: register ALUOp, rd, op1, op2.
  - Legal op: go to WAIT at T+1.
  - Illegal op: illegal_op=1 during T+1 only, no FPU activity, stay IDLE.
- WAIT: fpu_distinct=1, fpu_AorF=1, stall=1; fpu_op1/op2/ALUOp held constant.
  - Counter increments each cycle.
  - fpu_valid==1 at posedge V: capture fpu_result and fpu_AorF_. wb_valid=1, wb_fp, wb_rd and wb_data are driven during cycle V+1. Go to GAP.
  - Counter reaches TIMEOUT without fpu_valid: set err_timeout, no writeback, go to GAP.
  - fpu_valid and timeout in the same cycle: fpu_valid wins, writeback occurs.
- GAP: fpu_distinct=0, fpu_AorF=0, stall=1, wb_valid=0 after V+1.
  - Exit to IDLE at the first posedge with fpu_valid==0. The FPU holds valid for 2 cycles, so the earliest IDLE is V+2.
  - GAP lasts at least 1 cycle, which guarantees a falling edge on fpu_distinct between operations.
- Other outputs:
  - stall = (state != IDLE); issue_ready = (state == IDLE).
  - fpu_valid seen in IDLE is ignored.
  - wb_data is passed unmodified; compare results arrive zero-extended (bit0 meaningful).
  - wb_* hold their last value when wb_valid=0.
  - err_timeout clears only on reset.
- No back-pressure on writeback: the consumer accepts wb_valid unconditionally.

Test Plan:
- fadd: ALUOp 0011, op1 0x3F800000, op2 0x40000000, rd 7. Required: one wb_valid pulse, wb_data 0x40400000, wb_fp 1, wb_rd 7; stall high from accept+1 through GAP; exactly one fpu_distinct rising edge.
- fclt: ALUOp 1010, op1 0x3F800000, op2 0x40000000, rd 3. Required: wb_data 0x00000001, wb_fp 0; fceq with the same operands gives wb_data 0x00000000.
- Back-to-back: issue_valid held high with fdiv then fmul. Required: second op accepted only after GAP exit; fpu_distinct low for at least 1 cycle between ops; two wb pulses in order with correct rd.
- Illegal ALUOp 0000. Required: illegal_op pulse 1 cycle, fpu_distinct never rises, no wb_valid, issue_ready stays 1.
- TIMEOUT=16 with a stub FPU that never asserts valid. Required: err_timeout rises after 16 WAIT cycles, no wb_valid, return to IDLE, next op processes normally with err_timeout still 1.
- reset=0 for 1 cycle mid-WAIT. Required: next cycle IDLE, stall 0, fpu_distinct 0, err_timeout 0, no wb_valid even if fpu_valid arrives afterwards.
